elevator_car_controller: RTL and testbench
==========================================

Name: elevator_car_controller

Overview:
- Per-car sequencer for the elevator design: latches hall/car floor calls, chooses direction with a SCAN policy, times car travel between floors, and times door dwell.
- Consumes the overload flag from the car occupancy counter and blocks departure while it is set.
- Drives the motor and door actuators plus floor indication.

Parameters:
- N_FLOORS, 4, number of served floors (2..16).
- MOVE_TICKS, 16, clk cycles to travel one floor (>=1).
- DOOR_TICKS, 8, clk cycles of door dwell (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- call_n  in  N_FLOORS  floor call buttons, active-low, one bit per floor, may be held.
- overload  in  1  car overload, active-high, from the occupancy counter alarm.
- floor  out  FW=$clog2(N_FLOORS)  current/last-passed floor.
- motor_up  out  1  drive car upward.
- motor_down  out  1  drive car downward.
- door_open  out  1  door open command.
- pending  out  N_FLOORS  latched outstanding requests.
- overload_lamp  out  1  lit while departure is blocked by overload.

Behaviour:
- Reset (async, reset=0): state=IDLE, floor=0, dir=UP, pending=0, timer=0, all outputs 0. Reset mid-move or mid-dwell aborts immediately; no request survives reset.
- Request latch, every edge: pending[i] <= pending[i] | ~call_n[i], except bits cleared this edge (clear wins).
- If call_n[floor]=0 while in DOOR: pending[floor] is not set and the dwell timer reloads.
- States: IDLE, DOOR, MOVE_UP, MOVE_DOWN. motor_up=1 only in MOVE_UP. motor_down=1 only in MOVE_DOWN. door_open=1 only in DOOR. The motor and door are never active in the same cycle.
- Definitions: above = |pending[N-1:floor+1]; below = |pending[floor-1:0]; here = pending[floor] (all use registered pending).
- IDLE, priority order:
  - here -> DOOR (clear pending[floor], timer=0).
  - above and (dir==UP or !below) -> MOVE_UP, dir=UP.
  - below -> MOVE_DOWN, dir=DOWN.
  - else stay in IDLE.
- Latency: a call at the current floor, sampled at edge E0, gives door_open=1 after E1.
- MOVE_UP / MOVE_DOWN:
  - timer counts 0..MOVE_TICKS-1.
  - At the edge where timer==MOVE_TICKS-1: floor +/-1, timer=0, then the arrival decision is made on the new floor in the same edge.
  - Arrival: pending[new] -> DOOR (clear pending[new]); else requests remain further in dir -> stay in MOVE; else -> IDLE.
  - floor is saturating by construction: MOVE_UP is never entered at N-1, MOVE_DOWN is never entered at 0. The bench asserts this.
- DOOR:
  - timer counts 0..DOOR_TICKS-1.
  - At expiry: if overload=1, stay in DOOR with timer held at DOOR_TICKS-1 and overload_lamp=1; else -> IDLE, overload_lamp=0.
  - overload deasserting releases the door on the next edge.
  - overload outside DOOR is ignored; the car never stops mid-floor for it.
- Simultaneous events: a call for the floor being arrived at in the arrival cycle is served by that same door cycle and is not left pending.
- Arithmetic: timer width $clog2(max(MOVE_TICKS,DOOR_TICKS)+1). floor adds/subtracts are FW-bit with no wrap possible.

Optional Feature:
- EMERGENCY_STOP_EN.
- Defined: adds input estop_n (1, active-low).
  - estop_n=0 in any state -> next edge enters HALT: motors 0, door_open 0, timer frozen, pending still latches.
  - estop_n=1 -> returns to the saved state and resumes the timer from its frozen value.
- Undefined: no port, no HALT state, no extra logic.

Decomposition:
- Package elevator_pkg:
  - state encoding (IDLE, DOOR, MOVE_UP, MOVE_DOWN, HALT).
  - dir encoding (UP=0, DOWN=1).
  - floor-width helper function.
- Sub-module tick_timer: loadable up-counter with terminal flag, parameter WIDTH, inputs clear/enable. One instance is shared by the move and door phases.

Test Plan (N_FLOORS=4, MOVE_TICKS=3, DOOR_TICKS=4):
- Reset asserted mid-MOVE_UP at floor 1 -> same cycle: floor=0, motors=0, pending=0, state IDLE.
- At floor 0 IDLE, call_n=4'b1110 for 1 cycle -> door_open=1 from the 2nd edge for exactly 4 cycles, pending stays 0, then IDLE.
- At floor 0, call_n=4'b0111 for 1 cycle -> motor_up 9 cycles, floor steps 1,2,3 every 3 cycles, pending[3] clears on arrival, door_open 4 cycles.
- At floor 0, call floor 3, then floor 1 and floor 0 during the first move cycle -> stops at 1 (door), 3 (door), then MOVE_DOWN to 0 (door); SCAN order 1,3,0.
- overload=1 held through a DOOR expiry -> door_open stays 1, overload_lamp=1, motors 0 despite pending[2]; drop overload -> IDLE next edge, then MOVE_UP.
- With EMERGENCY_STOP_EN, estop_n=0 for 5 cycles mid-MOVE_UP -> motors 0 for 5 cycles, floor unchanged; on release, travel completes with the remaining timer ticks.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction encodings and the floor-width helper
// used by the elevator car controller.
package elevator_pkg;
    typedef enum logic [2:0] {IDLE, DOOR, MOVE_UP, MOVE_DOWN, HALT} state_t;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
    function automatic int floor_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tick_timer.sv
// tick_timer: up-counter cleared (loaded with zero) on demand, advancing when
// enabled, with a flag raised while the count equals the requested terminal.
module tick_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_done
);
    logic [WIDTH-1:0] r_count;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_count <= '0;
        else if (i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + WIDTH'(1);
    assign o_done = r_count == i_term;
endmodule

// File: rtl/elevator_car_controller.sv
// elevator_car_controller: per-car SCAN sequencer with move/door timing and overload hold.
// Optional EMERGENCY_STOP_EN adds estop_n and a HALT state that freezes the car in place.
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int N_FLOORS   = 4,
    parameter int MOVE_TICKS = 16,
    parameter int DOOR_TICKS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_FLOORS-1:0]          call_n,
    input  logic                         overload,
`ifdef EMERGENCY_STOP_EN
    input  logic                         estop_n,
`endif
    output logic [floor_w(N_FLOORS)-1:0] floor,
    output logic                         motor_up,
    output logic                         motor_down,
    output logic                         door_open,
    output logic [N_FLOORS-1:0]          pending,
    output logic                         overload_lamp
);
    localparam int FW   = floor_w(N_FLOORS);
    localparam int TMAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    state_t              r_state, w_next;
    dir_t                r_dir, w_dir_next;
    logic [FW-1:0]       r_floor, w_floor_next, w_adj;
    logic [N_FLOORS-1:0] r_pending, w_clr;
    logic                w_here, w_above, w_below, w_arr_hit, w_further;
    logic                w_t_clear, w_t_en, w_t_done, r_lamp, w_lamp_next;
`ifdef EMERGENCY_STOP_EN
    state_t              r_saved;
`endif

    function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
        return |((p >> f) >> 1);
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [FW-1:0] f);
        return |(p & ((N_FLOORS'(1) << f) - N_FLOORS'(1)));
    endfunction

    assign w_here    = r_pending[r_floor];
    assign w_above   = any_above(r_pending, r_floor);
    assign w_below   = any_below(r_pending, r_floor);
    // Floor the car reaches when the current move timer expires.
    assign w_adj     = (r_state == MOVE_UP) ? r_floor + FW'(1) : r_floor - FW'(1);
    assign w_arr_hit = r_pending[w_adj] | ~call_n[w_adj];
    assign w_further = (r_state == MOVE_UP) ? any_above(r_pending, w_adj) : any_below(r_pending, w_adj);

    tick_timer #(.WIDTH(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_t_clear),
        .i_enable(w_t_en),
        .i_term  ((r_state == DOOR) ? TW'(DOOR_TICKS - 1) : TW'(MOVE_TICKS - 1)),
        .o_done  (w_t_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_dir     <= UP;
            r_floor   <= '0;
            r_pending <= '0;
            r_lamp    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dir     <= w_dir_next;
            r_floor   <= w_floor_next;
            r_pending <= (r_pending | ~call_n) & ~w_clr;
            r_lamp    <= w_lamp_next;
        end
    end

`ifdef EMERGENCY_STOP_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_saved <= IDLE;
        else if (!estop_n && r_state != HALT) r_saved <= r_state;
`endif

    always_comb begin
        w_next       = r_state;
        w_dir_next   = r_dir;
        w_floor_next = r_floor;
        w_clr        = '0;
        w_t_clear    = 1'b0;
        w_t_en       = 1'b0;
        w_lamp_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_t_clear = 1'b1;
                if (w_here) begin
                    w_next         = DOOR;
                    w_clr[r_floor] = 1'b1;
                end else if (w_above && (r_dir == UP || !w_below)) begin
                    w_next     = MOVE_UP;
                    w_dir_next = UP;
                end else if (w_below) begin
                    w_next     = MOVE_DOWN;
                    w_dir_next = DOWN;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                w_t_en = 1'b1;
                if (w_t_done) begin
                    w_t_clear    = 1'b1;
                    w_floor_next = w_adj;
                    if (w_arr_hit) begin
                        w_next       = DOOR;
                        w_clr[w_adj] = 1'b1;
                    end else if (!w_further) w_next = IDLE;
                end
            end
            DOOR: begin
                // A call at the open floor re-arms the dwell instead of queueing.
                w_clr[r_floor] = 1'b1;
                if (!call_n[r_floor]) w_t_clear = 1'b1;
                else if (!w_t_done) w_t_en = 1'b1;
                else if (overload) w_lamp_next = 1'b1;
                else begin
                    w_next    = IDLE;
                    w_t_clear = 1'b1;
                end
            end
            default: ;
        endcase
`ifdef EMERGENCY_STOP_EN
        if (!estop_n || r_state == HALT) begin
            w_next       = !estop_n ? HALT : r_saved;
            w_dir_next   = r_dir;
            w_floor_next = r_floor;
            w_clr        = '0;
            w_t_clear    = 1'b0;
            w_t_en       = 1'b0;
            w_lamp_next  = r_lamp;
        end
`endif
    end

    always_comb begin
        floor         = r_floor;
        pending       = r_pending;
        motor_up      = r_state == MOVE_UP;
        motor_down    = r_state == MOVE_DOWN;
        door_open     = r_state == DOOR;
        overload_lamp = r_lamp && r_state == DOOR;
    end
endmodule

// File: tb/tb_elevator_car_controller.sv
// tb_elevator_car_controller: scenario and random checks of the car controller
// against a floor/request-level reference model (N=4, MOVE=3, DOOR=4).
module tb_elevator_car_controller;
    localparam int N  = 4;
    localparam int MT = 3;
    localparam int DT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] call_n = '1;
    logic         overload = 1'b0;
`ifdef EMERGENCY_STOP_EN
    logic         estop_n = 1'b1;
`endif
    logic [1:0]   floor;
    logic         motor_up, motor_down, door_open, overload_lamp;
    logic [N-1:0] pending;
    logic [10:0]  obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 idle, 1 door, 2 going up, 3 going down, 4 halted.
    int       m_st, m_saved, m_dir, m_floor, m_t;
    bit [N-1:0] m_pend;
    bit       m_lamp;

    elevator_car_controller #(.N_FLOORS(N), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
        .clk          (clk),
        .reset        (reset),
        .call_n       (call_n),
        .overload     (overload),
`ifdef EMERGENCY_STOP_EN
        .estop_n      (estop_n),
`endif
        .floor        (floor),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .pending      (pending),
        .overload_lamp(overload_lamp)
    );

    always #5 clk = ~clk;

    assign obs = {floor, motor_up, motor_down, door_open, pending, overload_lamp};

    function automatic bit req_above(input int f);
        for (int i = f + 1; i < N; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_below(input int f);
        for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] exp_vec();
        return {2'(m_floor), m_st == 2, m_st == 3, m_st == 1, m_pend, m_lamp && m_st == 1};
    endfunction

    task automatic model_reset();
        m_st = 0; m_saved = 0; m_dir = 0; m_floor = 0; m_t = 0; m_pend = '0; m_lamp = 1'b0;
    endtask

    task automatic model_step();
        bit [N-1:0] calls;
        bit [N-1:0] clr;
        int nf;
        calls = ~call_n;
        clr = '0;
`ifdef EMERGENCY_STOP_EN
        if (!estop_n) begin
            if (m_st != 4) begin m_saved = m_st; m_st = 4; end
            m_pend |= calls;
            return;
        end
        if (m_st == 4) begin
            m_st = m_saved;
            m_pend |= calls;
            return;
        end
`endif
        m_lamp = 1'b0;
        case (m_st)
            0: begin
                if (m_pend[m_floor]) begin m_st = 1; clr[m_floor] = 1'b1; end
                else if (req_above(m_floor) && (m_dir == 0 || !req_below(m_floor))) begin m_st = 2; m_dir = 0; end
                else if (req_below(m_floor)) begin m_st = 3; m_dir = 1; end
            end
            2, 3: begin
                if (m_t < MT - 1) m_t++;
                else begin
                    nf = (m_st == 2) ? m_floor + 1 : m_floor - 1;
                    m_t = 0;
                    if (m_pend[nf] || calls[nf]) begin m_st = 1; clr[nf] = 1'b1; end
                    else if (!((m_st == 2) ? req_above(nf) : req_below(nf))) m_st = 0;
                    m_floor = nf;
                end
            end
            1: begin
                clr[m_floor] = 1'b1;
                if (calls[m_floor]) m_t = 0;
                else if (m_t < DT - 1) m_t++;
                else if (overload) m_lamp = 1'b1;
                else begin m_st = 0; m_t = 0; end
            end
            default: ;
        endcase
        m_pend = (m_pend | calls) & ~clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle(input int fl);
        call_n = '1;
        call_n[fl] = 1'b0;
        overload = 1'b0;
        tick();
        call_n = '1;
        for (int c = 0; c < 200 && !(m_st == 0 && m_pend == 0); c++) tick();
        if (!(m_st == 0 && m_pend == 0)) begin
            n_bad++;
            $display("FAIL settle_timeout: model state %0d pending %b, required idle and empty", m_st, m_pend);
        end
    endtask

    task automatic test_reset();
        bit hit;
        #12;
        model_reset();
        n_cmp++;
        if (obs !== 11'b0) begin n_bad++; $display("FAIL reset_state: got %b want %b", obs, 11'b0); end
        reset = 1'b1;
        call_n = 4'b0111;
        tick();
        call_n = '1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_approach: got %b want %b", obs, exp_vec()); end
            hit = floor == 2'd1 && motor_up;
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL reset_reach_f1: got floor %0d up %b want floor 1 moving up", floor, motor_up); end
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 11'b0) begin n_bad++; $display("FAIL reset_midmove: got %b want %b", obs, 11'b0); end
        #2 reset = 1'b1;
    endtask

    task automatic test_door_here();
        int n_door;
        n_door = 0;
        call_n = 4'b1110;
        tick();
        call_n = '1;
        n_cmp++;
        if (door_open !== 1'b0) begin n_bad++; $display("FAIL door_latency_e0: got %b want 0", door_open); end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL door_here: got %b want %b", obs, exp_vec()); end
            if (c == 0) begin
                n_cmp++;
                if (door_open !== 1'b1) begin n_bad++; $display("FAIL door_latency_e1: got %b want 1", door_open); end
            end
            n_door += int'(door_open);
        end
        n_cmp++;
        if (n_door != DT) begin n_bad++; $display("FAIL door_dwell: got %0d cycles want %0d", n_door, DT); end
    endtask

    task automatic test_travel_up();
        int n_up;
        n_up = 0;
        call_n = 4'b0111;
        tick();
        call_n = '1;
        for (int c = 0; c < 16; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL travel_up: got %b want %b", obs, exp_vec()); end
            n_up += int'(motor_up);
        end
        n_cmp++;
        if (n_up != 3 * MT) begin n_bad++; $display("FAIL travel_up_cycles: got %0d want %0d", n_up, 3 * MT); end
        n_cmp++;
        if (floor !== 2'd3 || pending[3] !== 1'b0) begin
            n_bad++; $display("FAIL travel_up_arrive: got floor %0d pend %b want floor 3 pend[3]=0", floor, pending);
        end
    endtask

    task automatic test_scan();
        int  q[$];
        bit  prev_door;
        settle(0);
        call_n = 4'b0111;
        tick();
        call_n = '1;
        tick();
        call_n = 4'b1100;
        prev_door = 1'b0;
        for (int c = 0; c < 80 && !(q.size() == 3 && m_st == 0); c++) begin
            tick();
            call_n = '1;
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL scan: got %b want %b", obs, exp_vec()); end
            if (door_open && !prev_door) q.push_back(int'(floor));
            prev_door = door_open;
        end
        n_cmp++;
        if (q.size() != 3 || q[0] != 1 || q[1] != 3 || q[2] != 0) begin
            n_bad++; $display("FAIL scan_order: got %p want '{1,3,0}", q);
        end
    endtask

    task automatic test_overload();
        bit lamp_seen;
        lamp_seen = 1'b0;
        settle(0);
        overload = 1'b1;
        call_n = 4'b1110;
        tick();
        call_n = '1;
        tick();
        call_n = 4'b1011;
        tick();
        call_n = '1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL overload_hold: got %b want %b", obs, exp_vec()); end
            lamp_seen |= overload_lamp;
        end
        n_cmp++;
        if (!lamp_seen || door_open !== 1'b1 || motor_up !== 1'b0 || pending[2] !== 1'b1) begin
            n_bad++; $display("FAIL overload_block: got lamp %b door %b up %b pend %b want 1 1 0 x1xx", lamp_seen, door_open, motor_up, pending);
        end
        overload = 1'b0;
        tick();
        n_cmp++;
        if (door_open !== 1'b0 || motor_up !== 1'b0 || overload_lamp !== 1'b0) begin
            n_bad++; $display("FAIL overload_release: got door %b up %b lamp %b want 0 0 0", door_open, motor_up, overload_lamp);
        end
        tick();
        n_cmp++;
        if (motor_up !== 1'b1) begin n_bad++; $display("FAIL overload_depart: got up %b want 1", motor_up); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL overload_after: got %b want %b", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) call_n[i] = $urandom_range(7) != 0;
            overload = $urandom_range(5) == 0;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL random: cycle %0d got %b want %b", c, obs, exp_vec()); end
            n_cmp++;
            if ((motor_up && floor == 2'd3) || (motor_down && floor == 2'd0) ||
                (int'(motor_up) + int'(motor_down) + int'(door_open) > 1)) begin
                n_bad++; $display("FAIL random_invariant: got up %b down %b door %b floor %0d want legal", motor_up, motor_down, door_open, floor);
            end
        end
        call_n = '1;
        overload = 1'b0;
    endtask

`ifdef EMERGENCY_STOP_EN
    task automatic test_estop();
        settle(0);
        call_n = 4'b1011;
        tick();
        call_n = '1;
        tick();
        tick();
        estop_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (motor_up !== 1'b0 || motor_down !== 1'b0 || floor !== 2'd0) begin
                n_bad++; $display("FAIL estop_halt: got up %b down %b floor %0d want 0 0 0", motor_up, motor_down, floor);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL estop_model: got %b want %b", obs, exp_vec()); end
        end
        estop_n = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        n_cmp++;
        if (floor !== 2'd1 || motor_up !== 1'b1) begin
            n_bad++; $display("FAIL estop_resume: got floor %0d up %b want 1 1", floor, motor_up);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL estop_after: got %b want %b", obs, exp_vec()); end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_door_here();
        test_travel_up();
        test_scan();
        test_overload();
        test_random();
`ifdef EMERGENCY_STOP_EN
        test_estop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
